// File: rtl/rx_baud_gen.sv
// rtl/rx_baud_gen.sv - UART receive bit-timing generator (optional 16x oversample: RX_BAUD_OVS16_EN)
module rx_baud_gen #(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 2083,
  parameter int FRAME_BITS  = 10
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Count_Sig,
  input  logic             Div_Load,
  input  logic [CNT_W-1:0] Div_Value,
  output logic             BPS_CLK,
  output logic             Bit_End,
  output logic             Frame_Done,
  output logic [3:0]       Bit_Cnt,
  output logic             Div_Err
`ifdef RX_BAUD_OVS16_EN
  ,
  output logic             Ovs_Tick
`endif
);

  // Smallest divisor that still yields distinct mid-bit and end-of-bit cycles
  // (and, with oversampling, a sub-period of at least two cycles).
`ifdef RX_BAUD_OVS16_EN
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(32);
`else
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(4);
`endif
  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_DEFAULT);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             div_err_q, div_err_d;

  logic             run;
  logic [CNT_W-1:0] div_last;
  logic [CNT_W-1:0] div_half;
  logic             bit_end;
  logic             frame_last;
  logic             load_ok;

  // Pulses are qualified by reset too, so nothing escapes while RSTn is low.
  always_comb begin
    run        = Count_Sig & RSTn;
    div_last   = div_q - CNT_W'(1);
    div_half   = div_q >> 1;
    bit_end    = run && (cnt_q == div_last);
    frame_last = (bit_cnt_q == LAST_BIT);
    load_ok    = Div_Load && !Count_Sig && (Div_Value >= DIV_MIN);
  end

  // Decoded outputs: all pulses come straight from the current counter state.
  always_comb begin
    BPS_CLK    = run && (cnt_q == div_half);
    Bit_End    = bit_end;
    Frame_Done = bit_end && frame_last;
    Bit_Cnt    = bit_cnt_q;
    Div_Err    = div_err_q;
  end

  // Divisor register and sticky error: loads are only honoured while idle.
  always_comb begin
    div_d     = div_q;
    div_err_d = div_err_q;
    if (Div_Load) begin
      if (load_ok) begin
        div_d     = Div_Value;
        div_err_d = 1'b0;
      end else begin
        div_err_d = 1'b1;
      end
    end
  end

  // Bit-period counter: held at zero while idle, wraps at the end of each bit.
  always_comb begin
    cnt_d = cnt_q;
    if (!Count_Sig) begin
      cnt_d = '0;
    end else if (cnt_q >= div_last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Bit index within the frame: advances on each bit end, wraps after the last bit.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (!Count_Sig) begin
      bit_cnt_d = '0;
    end else if (bit_end) begin
      if (frame_last) begin
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      div_q     <= DIV_RST;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      div_err_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      div_err_q <= div_err_d;
    end
  end

`ifdef RX_BAUD_OVS16_EN
  logic [CNT_W-1:0] ovs_q, ovs_d;
  logic [CNT_W-1:0] ovs_last;
  logic             ovs_tick;

  // Sub-period decode: one tick every div_r>>4 cycles.
  always_comb begin
    ovs_last = (div_q >> 4) - CNT_W'(1);
    ovs_tick = run && (ovs_q == ovs_last);
    Ovs_Tick = ovs_tick;
  end

  // Oversample counter restarts on each bit end so the last sub-period
  // of a bit absorbs the division remainder.
  always_comb begin
    ovs_d = ovs_q;
    if (!Count_Sig || bit_end || ovs_tick) begin
      ovs_d = '0;
    end else begin
      ovs_d = ovs_q + CNT_W'(1);
    end
  end

  // Oversample counter register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ovs_q <= '0;
    end else begin
      ovs_q <= ovs_d;
    end
  end
`endif

endmodule

// File: doc/rx_baud_gen.md
RX_BAUD_GEN -- requirements
Module: rx_baud_gen

Interface
REQ-001 Parameter CNT_W, default 16: width of the bit-period counter and divisor.
REQ-002 Parameter DIV_DEFAULT, default 2083: reset divisor in CLK cycles per bit.
REQ-003 Parameter FRAME_BITS, default 10: bit periods per frame (start + 8 data + stop); legal range 1..15.
REQ-004 CLK  input  1  single system clock; all logic on its rising edge.
REQ-005 RSTn  input  1  asynchronous, active-low reset.
REQ-006 Count_Sig  input  1  run enable; high while a frame is being received.
REQ-007 Div_Load  input  1  one-cycle request to load Div_Value.
REQ-008 Div_Value  input  CNT_W  new divisor.
REQ-009 BPS_CLK  output  1  one-cycle mid-bit sample pulse.
REQ-010 Bit_End  output  1  one-cycle pulse in the last cycle of each bit period.
REQ-011 Frame_Done  output  1  one-cycle pulse at the end of the last bit of a frame.
REQ-012 Bit_Cnt  output  4  index of the current bit period within the frame.
REQ-013 Div_Err  output  1  sticky flag for a rejected divisor load.
REQ-014 Ovs_Tick  output  1  16x oversample pulse; present only when RX_BAUD_OVS16_EN is defined.

Function
REQ-015 Divisor register div_r SHALL load Div_Value when Div_Load=1, Count_Sig=0 and Div_Value>=DIV_MIN; the new value takes effect from the next cycle.
REQ-016 DIV_MIN SHALL be 4 without RX_BAUD_OVS16_EN and 32 with it.
REQ-017 A Div_Load with Count_Sig=1 or Div_Value<DIV_MIN SHALL leave div_r unchanged and set Div_Err the next cycle.
REQ-018 Div_Err SHALL clear only on an accepted load or on reset.
REQ-019 Counter cnt SHALL be 0 in any cycle after a cycle with Count_Sig=0.
REQ-020 While Count_Sig=1, cnt SHALL increment by 1 per cycle and wrap from div_r-1 to 0.
REQ-021 BPS_CLK SHALL be the combinational decode Count_Sig=1 and cnt==div_r>>1 (floor).
REQ-022 Example: with div 2083, BPS_CLK asserts 1041 cycles after the first Count_Sig=1 cycle.
REQ-023 Bit_End SHALL be the combinational decode Count_Sig=1 and cnt==div_r-1.
REQ-024 Bit_Cnt SHALL be cleared while Count_Sig=0 and SHALL increment on each Bit_End.
REQ-025 When Bit_End occurs with Bit_Cnt==FRAME_BITS-1, Frame_Done SHALL assert in that cycle and Bit_Cnt SHALL wrap to 0.
REQ-026 Count_Sig falling mid-bit SHALL abort the frame: no BPS_CLK, Bit_End or Frame_Done pulse in the following cycle, and counters return to 0.
REQ-027 Count_Sig re-rising SHALL restart timing from cnt=0 and Bit_Cnt=0.

Reset
REQ-028 When RSTn=0, reset SHALL take effect asynchronously: div_r=DIV_DEFAULT, cnt=0, Bit_Cnt=0, Div_Err=0.
REQ-029 All pulse outputs SHALL be 0 during reset.
REQ-030 The first active edge after RSTn deasserts SHALL behave as Count_Sig-dependent normal operation.

Configuration
REQ-031 With macro RX_BAUD_OVS16_EN defined, an oversample counter SHALL generate Ovs_Tick each (div_r>>4) cycles while Count_Sig=1.
REQ-032 The oversample counter SHALL be cleared by Count_Sig=0 and by Bit_End, so the last sub-period of each bit absorbs the remainder.
REQ-033 Without RX_BAUD_OVS16_EN, the Ovs_Tick port and its logic SHALL be absent, and DIV_MIN=4.

Verification
REQ-034 Reset, then Count_Sig=1 for 20830 cycles with div 2083 -> BPS_CLK at cycles 1041+2083k, Bit_End at 2082+2083k, and Frame_Done once, at cycle 20829.
REQ-035 Div_Load with Div_Value=434 while idle -> div_r=434; the next frame gives BPS_CLK at cycles 217+434k and Div_Err=0.
REQ-036 Div_Load with Div_Value=2 (or 20 with macro) or while Count_Sig=1 -> div_r unchanged and Div_Err=1 until the next accepted load.
REQ-037 Count_Sig dropped at cnt=500 of bit 3, then raised again -> no pulses while low, Bit_Cnt=0, and the next BPS_CLK 1041 cycles after the rise.
REQ-038 RSTn asserted mid-frame with div 434 loaded -> outputs 0 immediately and div_r=2083 after release.
REQ-039 With the macro and div 2083 -> 16 Ovs_Tick pulses per bit, spaced 130 cycles, each train restarting after Bit_End.
